// File: rtl/shift_seq_counter.sv
// shift_seq_counter: ring/Johnson shift counter stepped by an internal
// clock-enable prescaler. It supports direction control and synchronous load.
// An illegal state is replaced by RST_VAL on the next step.
// Single clock domain. All outputs are registered.
module shift_seq_counter #(
  parameter int               WIDTH   = 4,
  parameter int               DIV     = 50_000_000,
  parameter logic [WIDTH-1:0] RST_VAL = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tick,
  output logic             wrap,
  output logic             err
);

  // The prescaler counts 0..DIV-1. With DIV = 1 the single bit never leaves
  // zero, so every enabled cycle is a step.
  localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic             step;
  logic             ring_legal;
  logic             john_legal;
  logic             legal;
  logic [WIDTH-1:0] ring_dn, ring_up, john_dn, john_up;
  logic [WIDTH-1:0] shifted;

  // Adjacent-bit transition map. A Johnson (thermometer) state has at most
  // one transition between neighbouring bits.
  logic [WIDTH-2:0] trans;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_trans
      assign trans[gi] = q_q[gi] ^ q_q[gi+1];
    end
  endgenerate

  // Legality of the current state under each mode.
  // A vector with at most one bit set is detected by (v & (v - 1)) == 0.
  assign ring_legal = (q_q != '0) && ((q_q & (q_q - WIDTH'(1))) == '0);
  assign john_legal = ((trans & (trans - (WIDTH-1)'(1))) == '0);
  assign legal      = mode ? john_legal : ring_legal;

  // The four shift functions. The Johnson forms invert the bit that wraps.
  assign ring_dn = {q_q[0], q_q[WIDTH-1:1]};
  assign ring_up = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign john_dn = {~q_q[0], q_q[WIDTH-1:1]};
  assign john_up = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};

  // Select the next shifted value from mode and direction.
  always_comb begin
    shifted = ring_dn;
    case ({mode, dir})
      2'b00:   shifted = ring_dn;
      2'b01:   shifted = ring_up;
      2'b10:   shifted = john_dn;
      default: shifted = john_up;
    endcase
  end

  // Prescaler. It produces a one-cycle step enable and holds while en is low.
  // A load restarts the period so the next step is a full DIV cycles away.
  always_comb begin
    cnt_d = cnt_q;
    step  = 1'b0;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        step  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Next state of the counter and its status pulses. Load has priority over
  // step, which has priority over hold. A step from an illegal state jumps to
  // RST_VAL and flags err instead of wrap.
  always_comb begin
    q_d    = q_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      q_d = load_val;
    end else if (step) begin
      tick_d = 1'b1;
      if (legal) begin
        q_d    = shifted;
        wrap_d = (shifted == RST_VAL);
      end else begin
        q_d   = RST_VAL;
        err_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset. Reset overrides load and step.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      q_q    <= RST_VAL;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign Q    = q_q;
  assign tick = tick_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_shift_seq_counter.sv
// Directed testbench for shift_seq_counter. The main instance uses
// WIDTH = 4 and DIV = 3. A second instance uses DIV = 1.
// Observed vector layout is {Q, tick, wrap, err}.
module tb_shift_seq_counter;

  logic       clk = 1'b0;
  logic       rst, en, mode, dir, load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tick, wrap, err;

  logic       rst1, en1, mode1, dir1, load1;
  logic [3:0] load_val1;
  logic [3:0] q1;
  logic       tick1, wrap1, err1;

  logic [6:0] obs, obs1;
  assign obs  = {q, tick, wrap, err};
  assign obs1 = {q1, tick1, wrap1, err1};

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  shift_seq_counter #(.WIDTH(4), .DIV(3)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val), .Q(q), .tick(tick), .wrap(wrap), .err(err)
  );

  shift_seq_counter #(.WIDTH(4), .DIV(1)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .mode(mode1), .dir(dir1), .load(load1),
    .load_val(load_val1), .Q(q1), .tick(tick1), .wrap(wrap1), .err(err1)
  );

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'b0;
    cycle(2);
    total++;
    if (obs !== 7'b1000_000) $display("FAIL reset: got %b want %b", obs, 7'b1000_000);
    else passed++;
    rst = 1'b0;
  endtask

  // Ring mode, shifting toward the LSB. Each step is preceded by two hold cycles.
  task automatic test_ring_down;
    logic [3:0] exp_q [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      cycle(2);
      total++;
      if (obs !== {exp_q[(i+3)%4], 3'b000})
        $display("FAIL ring_hold%0d: got %b want %b", i, obs, {exp_q[(i+3)%4], 3'b000});
      else passed++;
      cycle(1);
      total++;
      if (obs !== {exp_q[i], 1'b1, (i == 3), 1'b0})
        $display("FAIL ring_step%0d: got %b want %b", i, obs, {exp_q[i], 1'b1, (i == 3), 1'b0});
      else passed++;
    end
  endtask

  task automatic test_johnson_down;
    logic [3:0] exp_q [8] = '{4'b1100, 4'b1110, 4'b1111, 4'b0111,
                              4'b0011, 4'b0001, 4'b0000, 4'b1000};
    mode = 1'b1; dir = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(3);
      total++;
      if (obs !== {exp_q[i], 1'b1, (i == 7), 1'b0})
        $display("FAIL john_dn%0d: got %b want %b", i, obs, {exp_q[i], 1'b1, (i == 7), 1'b0});
      else passed++;
    end
  endtask

  task automatic test_johnson_up;
    logic [3:0] exp_q [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                              4'b1111, 4'b1110, 4'b1100, 4'b1000};
    mode = 1'b1; dir = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(3);
      total++;
      if (obs !== {exp_q[i], 1'b1, (i == 7), 1'b0})
        $display("FAIL john_up%0d: got %b want %b", i, obs, {exp_q[i], 1'b1, (i == 7), 1'b0});
      else passed++;
    end
  endtask

  // An illegal load is accepted, then corrected with err at the next step.
  task automatic test_load_illegal;
    mode = 1'b0; dir = 1'b0;
    load = 1'b1; load_val = 4'b0110;
    cycle(1);
    load = 1'b0;
    total++;
    if (obs !== 7'b0110_000) $display("FAIL load_ring: got %b want %b", obs, 7'b0110_000);
    else passed++;
    cycle(2);
    total++;
    if (obs !== 7'b0110_000) $display("FAIL load_ring_hold: got %b want %b", obs, 7'b0110_000);
    else passed++;
    cycle(1);
    total++;
    if (obs !== 7'b1000_101) $display("FAIL fix_ring: got %b want %b", obs, 7'b1000_101);
    else passed++;

    mode = 1'b1;
    load = 1'b1; load_val = 4'b0101;
    cycle(1);
    load = 1'b0;
    total++;
    if (obs !== 7'b0101_000) $display("FAIL load_john: got %b want %b", obs, 7'b0101_000);
    else passed++;
    cycle(3);
    total++;
    if (obs !== 7'b1000_101) $display("FAIL fix_john: got %b want %b", obs, 7'b1000_101);
    else passed++;
  endtask

  // A one-hot state that is legal in ring mode becomes illegal after a switch to Johnson.
  task automatic test_mode_change;
    mode = 1'b0; dir = 1'b0;
    cycle(3);
    total++;
    if (obs !== 7'b0100_100) $display("FAIL pre_switch: got %b want %b", obs, 7'b0100_100);
    else passed++;
    mode = 1'b1;
    cycle(3);
    total++;
    if (obs !== 7'b1000_101) $display("FAIL switch_err: got %b want %b", obs, 7'b1000_101);
    else passed++;
    mode = 1'b0;
  endtask

  // Holding en low for 5 cycles stretches the period from 3 to 8 edges.
  task automatic test_en_stall;
    cycle(1);
    en = 1'b0;
    cycle(5);
    total++;
    if (obs !== 7'b1000_000) $display("FAIL stall_hold: got %b want %b", obs, 7'b1000_000);
    else passed++;
    en = 1'b1;
    cycle(1);
    total++;
    if (obs !== 7'b1000_000) $display("FAIL stall_prestep: got %b want %b", obs, 7'b1000_000);
    else passed++;
    cycle(1);
    total++;
    if (obs !== 7'b0100_100) $display("FAIL stall_step: got %b want %b", obs, 7'b0100_100);
    else passed++;
  endtask

  // A load on a step cycle wins and restarts the prescaler.
  task automatic test_load_on_step;
    cycle(2);
    load = 1'b1; load_val = 4'b0001;
    cycle(1);
    load = 1'b0;
    total++;
    if (obs !== 7'b0001_000) $display("FAIL load_step: got %b want %b", obs, 7'b0001_000);
    else passed++;
    cycle(2);
    total++;
    if (obs !== 7'b0001_000) $display("FAIL load_restart: got %b want %b", obs, 7'b0001_000);
    else passed++;
    cycle(1);
    total++;
    if (obs !== 7'b1000_110) $display("FAIL load_wrap: got %b want %b", obs, 7'b1000_110);
    else passed++;
  endtask

  // Reset overrides a concurrent load, and also a step that would have wrapped.
  task automatic test_rst_priority;
    cycle(2);
    rst = 1'b1; load = 1'b1; load_val = 4'b0010;
    cycle(1);
    rst = 1'b0; load = 1'b0;
    total++;
    if (obs !== 7'b1000_000) $display("FAIL rst_load: got %b want %b", obs, 7'b1000_000);
    else passed++;
    cycle(3);
    total++;
    if (obs !== 7'b0100_100) $display("FAIL rst_resume: got %b want %b", obs, 7'b0100_100);
    else passed++;

    load = 1'b1; load_val = 4'b0001;
    cycle(1);
    load = 1'b0;
    cycle(2);
    rst = 1'b1;
    cycle(1);
    rst = 1'b0;
    total++;
    if (obs !== 7'b1000_000) $display("FAIL rst_wrapstep: got %b want %b", obs, 7'b1000_000);
    else passed++;
  endtask

  // With DIV = 1 the counter steps on every enabled cycle.
  task automatic test_div1;
    logic [3:0] exp_q [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    total++;
    if (obs1 !== 7'b1000_000) $display("FAIL div1_reset: got %b want %b", obs1, 7'b1000_000);
    else passed++;
    rst1 = 1'b0; en1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1);
      total++;
      if (obs1 !== {exp_q[i], 1'b1, (i == 3), 1'b0})
        $display("FAIL div1_step%0d: got %b want %b", i, obs1, {exp_q[i], 1'b1, (i == 3), 1'b0});
      else passed++;
    end
    en1 = 1'b0;
    cycle(1);
    total++;
    if (obs1 !== 7'b1000_000) $display("FAIL div1_hold: got %b want %b", obs1, 7'b1000_000);
    else passed++;
    en1 = 1'b1;
    cycle(1);
    total++;
    if (obs1 !== 7'b0100_100) $display("FAIL div1_resume: got %b want %b", obs1, 7'b0100_100);
    else passed++;
  endtask

  initial begin
    rst1 = 1'b1; en1 = 1'b0; mode1 = 1'b0; dir1 = 1'b0; load1 = 1'b0; load_val1 = 4'b0;
    test_reset;
    test_ring_down;
    test_johnson_down;
    test_johnson_up;
    test_load_illegal;
    test_mode_change;
    test_en_stall;
    test_load_on_step;
    test_rst_priority;
    test_div1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shift_seq_counter.md
# shift_seq_counter

Parametrised ring/Johnson shift counter with an internal clock-enable prescaler, direction control, synchronous load and illegal-state self-correction. It drives LED or sequencing outputs at a human-visible step rate from the board clock. All logic runs on the single system clock; the prescaler produces a one-cycle enable, not a derived clock.

## Interface

**Parameters**

- WIDTH, default 4: counter width in bits; legal range ≥ 2.
- DIV, default 50_000_000: step period in clk cycles; legal range ≥ 1. DIV = 1 steps every enabled cycle.
- RST_VAL, default {1'b1, {WIDTH-1{1'b0}}} (4'b1000 at WIDTH = 4): reset and wrap-reference state. It must be one-hot.

**Ports**

- clk, input, 1: system clock; all state changes on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: when low, the prescaler and Q hold.
- mode, input, 1: 0 = ring, 1 = Johnson.
- dir, input, 1: 0 = shift toward LSB, 1 = shift toward MSB.
- load, input, 1: synchronous load of load_val.
- load_val, input, WIDTH: value for load.
- Q, output, WIDTH: counter state (registered).
- tick, output, 1: one-cycle pulse in the cycle Q shows a stepped value.
- wrap, output, 1: one-cycle pulse when a normal step makes Q equal RST_VAL.
- err, output, 1: one-cycle pulse when a step replaced an illegal Q with RST_VAL.

## Operation

**Reset (rst = 1 at an edge)**

- Q = RST_VAL, prescaler = 0, tick = wrap = err = 0.

**Prescaler**

- cnt is 0..DIV-1, with width max(1, $clog2(DIV)).
- When en = 1: if cnt == DIV-1, then step = 1 and cnt = 0; otherwise cnt increments.
- When en = 0: cnt holds and step = 0.

**Priority per edge: rst > load > step > hold**

- Load: Q = load_val and cnt = 0, regardless of en. tick, wrap and err are 0. A pending step in the same cycle is discarded. An illegal load_val is accepted and corrected at the next step.
- Step: check legality of the current Q under the current mode.
  - Legal: apply the shift and set tick = 1. Set wrap = 1 if the new Q == RST_VAL.
  - Illegal: set Q = RST_VAL, tick = 1, err = 1, wrap = 0.
- Otherwise: Q holds and tick, wrap and err are 0.

**Shift functions**

- Ring, dir = 0: {Q[0], Q[W-1:1]}.
- Ring, dir = 1: {Q[W-2:0], Q[W-1]}.
- Johnson, dir = 0: {~Q[0], Q[W-1:1]}.
- Johnson, dir = 1: {Q[W-2:0], ~Q[W-1]}.

**Legality**

- Ring: Q has exactly one bit set (WIDTH legal states).
- Johnson: the number of i in 0..W-2 with Q[i] != Q[i+1] is ≤ 1. These are the 2·WIDTH thermometer states.
- Ring states 10..0 and 0..01 are also Johnson-legal. All other one-hot values are Johnson-illegal.

**Mode and dir changes**

- Both take effect at the next step; there is no immediate correction.
- A state that is illegal under the new mode is corrected at that step, with err = 1.

**Sequence lengths**

- Ring: WIDTH steps from RST_VAL back to RST_VAL.
- Johnson: 2·WIDTH steps.
- wrap fires once per full period.

## Timing

- After rst deasserts with en = 1, the first step occurs on the DIV-th rising edge. Q changes and tick = 1 in the following cycle.
- Steps then occur every DIV enabled cycles. Deasserting en stretches the period by exactly the number of disabled cycles.
- Load has 1-cycle latency. The next step is DIV enabled cycles after the load edge.
- tick, wrap and err are registered on the same edge as Q and are never asserted for more than one cycle.
- rst mid-sequence takes effect on the next edge, overriding load and step.

## Test plan

- WIDTH=4, DIV=3, mode=0, dir=0, en=1 after reset: Q = 1000, 0100, 0010, 0001, 1000 at 3-cycle spacing. wrap on the last step only; tick on each step.
- mode=1, dir=0: Q = 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000, 1000. wrap once per 8 steps; err never.
- mode=1, dir=1 from 1000: Q = 0001, 0011, 0111, 1111, 1110, 1100, 1000. wrap on the 8th step (via 0000).
- load with load_val = 0110, mode=0: Q = 0110 the next cycle with tick = 0. The next step gives Q = 1000 and err = 1. With mode=1 and load 0101, the next step gives 1000 and err = 1.
- Toggle en low for 5 cycles mid-period (DIV=3): the step is delayed by exactly 5 cycles. load asserted on a step cycle: Q = load_val, tick = 0, and the prescaler restarts.
- rst asserted together with load and on a step cycle: Q = 1000 and tick = wrap = err = 0. With DIV=1, Q steps every enabled cycle.
